dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the byte-lane data memory (4x8 BRAM with width/sign access).
- Port m0 is the CPU MEM stage; port m1 is the IO/DMA master (UART loader back-end, peripherals).
- Grants one requester at a time and drives the memory's address/width/sign/write signals.
- Holds address/width/sign stable across the one-cycle BRAM read latency, then returns read data through a valid/ready response channel. Misaligned accesses are screened before they reach the memory.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_arb_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: width encodings, sequencer states and the misalignment rule shared by the arbiter.
package dmem_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    // Mirrors the memory's own screening so a bad access never reaches it.
    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lsb);
        return (width == WIDTH_HALF && lsb[0]) ||
               (width == WIDTH_WORD && lsb != 2'b00) ||
               (width != WIDTH_BYTE && width != WIDTH_HALF && width != WIDTH_WORD);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: two-way picker with one-hot grant; m0 fixed priority by default,
// round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
`ifdef DMEM_ARB_RR_EN
    logic ptr;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ptr <= 1'b0;
        else if (|gnt_o)
            ptr <= gnt_o[0];
    end
    assign gnt_o = {req_i[1] & (ptr | ~req_i[0]), req_i[0] & ~(ptr & req_i[1])};
`else
    logic unused;
    assign unused = clk_i ^ rst_i;
    assign gnt_o = {req_i[1] & ~req_i[0], req_i[0]};
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the byte-lane data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of m0 fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [1:0]        m0_width_i,
    input  logic              m0_sign_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic              m0_gnt_o,
    output logic              m0_rsp_valid_o,
    input  logic              m0_rsp_ready_i,
    output logic [DATA_W-1:0] m0_rsp_dat_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [1:0]        m1_width_i,
    input  logic              m1_sign_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic              m1_gnt_o,
    output logic              m1_rsp_valid_o,
    input  logic              m1_rsp_ready_i,
    output logic [DATA_W-1:0] m1_rsp_dat_o,
    output logic              m1_err_o,
    output logic              mem_wen_o,
    output logic [1:0]        mem_width_o,
    output logic              mem_sign_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [DATA_W-1:0] mem_dat_o,
    input  logic [DATA_W-1:0] mem_dat_i
);
    state_t state, state_nx;
    logic [1:0] req, gnt, w_width, width_q, err_q;
    logic any, win, w_we, w_sign, w_mis, owner, sign_q, mis_q, ready;
    logic [ADDR_W-1:0] w_adr, adr_q;
    logic [DATA_W-1:0] w_dat;
    logic [1:0][DATA_W-1:0] rsp_dat_q;

    // Grants only from IDLE and never while reset is asserted.
    assign req = {m1_req_i, m0_req_i} & {2{state == IDLE && !rst_i}};

    dmem_arb_pick u_pick (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req),
        .gnt_o(gnt)
    );

    always_comb begin
        any = |gnt;
        win = gnt[1];
        w_we = win ? m1_we_i : m0_we_i;
        w_width = win ? m1_width_i : m0_width_i;
        w_sign = win ? m1_sign_i : m0_sign_i;
        w_adr = win ? m1_adr_i : m0_adr_i;
        w_dat = win ? m1_dat_i : m0_dat_i;
        w_mis = misaligned(w_width, w_adr[1:0]);
        ready = owner ? m1_rsp_ready_i : m0_rsp_ready_i;
        state_nx = state;
        case (state)
            IDLE:    state_nx = (any && !w_we) ? RD_WAIT : IDLE;
            RD_WAIT: state_nx = RESP;
            default: state_nx = ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            owner <= 1'b0;
            adr_q <= '0;
            width_q <= '0;
            sign_q <= 1'b0;
            mis_q <= 1'b0;
            err_q <= '0;
            rsp_dat_q <= '0;
        end else begin
            state <= state_nx;
            if (any) begin
                owner <= win;
                adr_q <= w_adr;
                width_q <= w_width;
                sign_q <= w_sign;
                mis_q <= w_mis;
            end
            if (state == RD_WAIT) begin
                rsp_dat_q[owner] <= mis_q ? '0 : mem_dat_i;
                err_q[owner] <= mis_q;
            end
        end
    end

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];
    assign m0_rsp_valid_o = state == RESP && !owner;
    assign m1_rsp_valid_o = state == RESP && owner;
    assign m0_rsp_dat_o = rsp_dat_q[0];
    assign m1_rsp_dat_o = rsp_dat_q[1];
    assign m0_err_o = (gnt[0] & m0_we_i & w_mis) | (m0_rsp_valid_o & err_q[0]);
    assign m1_err_o = (gnt[1] & m1_we_i & w_mis) | (m1_rsp_valid_o & err_q[1]);
    // Latched copies keep the read address stable through the BRAM latency.
    assign mem_wen_o = any & w_we & ~w_mis;
    assign mem_adr_o = any ? w_adr : adr_q;
    assign mem_width_o = any ? w_width : width_q;
    assign mem_sign_o = any ? w_sign : sign_q;
    assign mem_dat_o = any ? w_dat : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized check of dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req = '0, we = '0, sign = '0, rdy = 2'b11;
    logic [1:0] width [2];
    logic [15:0] adr [2];
    logic [31:0] dat [2];
    logic [1:0] gnt, rv, err;
    logic [31:0] rdat [2];
    logic mem_wen_o, mem_sign_o;
    logic [1:0] mem_width_o;
    logic [15:0] mem_adr_o;
    logic [31:0] mem_dat_o, mem_rd = '0;
    logic [7:0] mem [2][64];
    int total = 0, bad = 0;
    logic [1:0] seen_g = '0;
    bit busy = 0, fav = 0, lsign, lerr;
    int age, owner;
    logic [15:0] ladr;
    logic [1:0] lwidth;
    logic [31:0] ldat;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_width_i(width[0]), .m0_sign_i(sign[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_gnt_o(gnt[0]), .m0_rsp_valid_o(rv[0]),
        .m0_rsp_ready_i(rdy[0]), .m0_rsp_dat_o(rdat[0]), .m0_err_o(err[0]),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_width_i(width[1]), .m1_sign_i(sign[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_gnt_o(gnt[1]), .m1_rsp_valid_o(rv[1]),
        .m1_rsp_ready_i(rdy[1]), .m1_rsp_dat_o(rdat[1]), .m1_err_o(err[1]),
        .mem_wen_o(mem_wen_o), .mem_width_o(mem_width_o), .mem_sign_o(mem_sign_o),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_rd)
    );

    function automatic logic mis(logic [1:0] w, logic [15:0] a);
        return (w == 2'b10) || (w == 2'b01 && a[0]) || (w == 2'b11 && a[1:0] != 2'b00);
    endfunction

    // mem[0] is the golden image, mem[1] is the memory seen by the DUT.
    function automatic logic [31:0] rd(int m, logic [15:0] a, logic [1:0] w, logic s);
        int b = int'(a[5:0]);
        logic [31:0] v;
        v = {mem[m][(b + 3) & 63], mem[m][(b + 2) & 63], mem[m][(b + 1) & 63], mem[m][b]};
        case (w)
            2'b00: v = s ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
            2'b01: v = s ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
            2'b11: v = v;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic void wr(int m, logic [15:0] a, logic [1:0] w, logic [31:0] d);
        int b = int'(a[5:0]);
        int l = int'(a[1:0]);
        int n = w == 2'b00 ? 1 : w == 2'b01 ? 2 : w == 2'b11 ? 4 : 0;
        for (int k = 0; k < n; k++) mem[m][(b + k) & 63] = d[8 * (l + k) +: 8];
    endfunction

    always @(posedge clk) begin
        mem_rd <= rd(1, mem_adr_o, mem_width_o, mem_sign_o);
        if (mem_wen_o) wr(1, mem_adr_o, mem_width_o, mem_dat_o);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Model: at most one outstanding load; a load answers from cycle grant+2 until ready.
    always @(negedge clk) begin
        logic [1:0] eg, ev;
        int w;
        eg = 2'b00;
        if (!rst && !busy) eg = (req == 2'b11) ? (fav ? 2'b10 : 2'b01) : req;
        w = eg[1] ? 1 : 0;
        ev = (busy && age >= 2) ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00;
        chk("gnt", {30'd0, gnt}, {30'd0, eg});
        chk("rsp_valid", {30'd0, rv}, {30'd0, ev});
        chk("wen", {31'd0, mem_wen_o}, {31'd0, |eg && we[w] && !mis(width[w], adr[w])});
        for (int n = 0; n < 2; n++) begin
            chk("err", {31'd0, err[n]}, {31'd0, (eg[n] && we[n] && mis(width[n], adr[n])) || (ev[n] && lerr)});
            if (ev[n]) chk("rsp_dat", rdat[n], ldat);
        end
        if (|eg) begin
            chk("mem_adr", {16'd0, mem_adr_o}, {16'd0, adr[w]});
            chk("mem_width", {30'd0, mem_width_o}, {30'd0, width[w]});
            chk("mem_sign", {31'd0, mem_sign_o}, {31'd0, sign[w]});
            if (we[w]) chk("mem_dat", mem_dat_o, dat[w]);
        end else if (busy && age == 1) begin
            chk("hold_adr", {16'd0, mem_adr_o}, {16'd0, ladr});
            chk("hold_width", {30'd0, mem_width_o}, {30'd0, lwidth});
            chk("hold_sign", {31'd0, mem_sign_o}, {31'd0, lsign});
        end
        seen_g = gnt;
        if (rst) begin
            busy = 0;
            fav = 0;
        end else begin
            if (busy) begin
                if (age >= 2 && rdy[owner]) busy = 0;
                else age++;
            end
            if (|eg) begin
                if (RR) fav = eg[0];
                if (we[w]) begin
                    if (!mis(width[w], adr[w])) wr(0, adr[w], width[w], dat[w]);
                end else begin
                    busy = 1;
                    age = 1;
                    owner = w;
                    ladr = adr[w];
                    lwidth = width[w];
                    lsign = sign[w];
                    lerr = mis(width[w], adr[w]);
                    ldat = lerr ? 32'd0 : rd(0, adr[w], width[w], sign[w]);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int n, logic w, logic [1:0] wd, logic s, logic [15:0] a, logic [31:0] d);
        we[n] = w;
        width[n] = wd;
        sign[n] = s;
        adr[n] = a;
        dat[n] = d;
        req[n] = 1'b1;
    endtask

    initial begin
        int g0;
        for (int n = 0; n < 2; n++) begin
            width[n] = 2'b00;
            adr[n] = '0;
            dat[n] = '0;
        end
        for (int i = 0; i < 64; i++) begin
            mem[0][i] = 8'($urandom);
            mem[1][i] = mem[0][i];
        end
        for (int m = 0; m < 2; m++) begin
            {mem[m][3], mem[m][2], mem[m][1], mem[m][0]} = 32'h11223344;
            {mem[m][19], mem[m][18], mem[m][17], mem[m][16]} = 32'hDEADBEEF;
            mem[m][5] = 8'h80;
        end
        repeat (3) nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_valid", {30'd0, rv}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        chk("rst_adr", {16'd0, mem_adr_o}, 32'd0);
        nxt();
        // m0 word load
        issue(0, 1'b0, 2'b11, 1'b0, 16'h0010, 32'd0);
        @(negedge clk);
        chk("ld_gnt", {31'd0, gnt[0]}, 32'd1);
        chk("ld_adr_t", {16'd0, mem_adr_o}, 32'h10);
        nxt();
        req[0] = 1'b0;
        @(negedge clk);
        chk("ld_adr_t1", {16'd0, mem_adr_o}, 32'h10);
        chk("ld_valid_t1", {31'd0, rv[0]}, 32'd0);
        nxt();
        @(negedge clk);
        chk("ld_valid_t2", {31'd0, rv[0]}, 32'd1);
        chk("ld_dat", rdat[0], 32'hDEADBEEF);
        chk("ld_err", {31'd0, err[0]}, 32'd0);
        nxt();
        // misaligned m1 half store
        issue(1, 1'b1, 2'b01, 1'b0, 16'h0003, 32'h12345678);
        @(negedge clk);
        chk("st_gnt", {31'd0, gnt[1]}, 32'd1);
        chk("st_err", {31'd0, err[1]}, 32'd1);
        chk("st_wen", {31'd0, mem_wen_o}, 32'd0);
        nxt();
        req[1] = 1'b0;
        issue(0, 1'b0, 2'b11, 1'b0, 16'h0000, 32'd0);
        nxt();
        req[0] = 1'b0;
        nxt();
        @(negedge clk);
        chk("st_unchanged", rdat[0], 32'h11223344);
        nxt();
        // contention with m0 response stalled 5 cycles
        rdy[0] = 1'b0;
        issue(0, 1'b0, 2'b11, 1'b0, 16'h0010, 32'd0);
        issue(1, 1'b0, 2'b00, 1'b1, 16'h0005, 32'd0);
        @(negedge clk);
        chk("both_gnt", {30'd0, gnt}, 32'd1);
        nxt();
        req[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("m1_held", {31'd0, gnt[1]}, 32'd0);
            if (i >= 2) chk("m0_stall_valid", {31'd0, rv[0]}, 32'd1);
            nxt();
        end
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("m1_held_ready", {31'd0, gnt[1]}, 32'd0);
        chk("m0_stall_dat", rdat[0], 32'hDEADBEEF);
        nxt();
        @(negedge clk);
        chk("m1_after", {31'd0, gnt[1]}, 32'd1);
        nxt();
        req[1] = 1'b0;
        nxt();
        @(negedge clk);
        chk("sbyte_valid", {31'd0, rv[1]}, 32'd1);
        chk("sbyte_dat", rdat[1], 32'hFFFFFF80);
        nxt();
        issue(1, 1'b0, 2'b00, 1'b0, 16'h0005, 32'd0);
        nxt();
        req[1] = 1'b0;
        nxt();
        @(negedge clk);
        chk("ubyte_dat", rdat[1], 32'h00000080);
        nxt();
        // continuous stores from both
        issue(0, 1'b1, 2'b11, 1'b0, 16'h0020, 32'hA0A0A0A0);
        issue(1, 1'b1, 2'b11, 1'b0, 16'h0024, 32'hB1B1B1B1);
        g0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("store_order", {30'd0, gnt}, (RR && i % 2 == 1) ? 32'd2 : 32'd1);
            g0 += int'(gnt[0]);
            nxt();
        end
        req = 2'b00;
        chk("store_m0_count", g0, RR ? 32'd2 : 32'd4);
        // reset during RESP
        rdy[1] = 1'b0;
        issue(1, 1'b0, 2'b11, 1'b0, 16'h0010, 32'd0);
        @(negedge clk);
        chk("pre_rst_gnt", {31'd0, gnt[1]}, 32'd1);
        nxt();
        req[1] = 1'b0;
        nxt();
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, rv[1]}, 32'd1);
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        rdy[1] = 1'b1;
        issue(1, 1'b0, 2'b11, 1'b0, 16'h0010, 32'd0);
        @(negedge clk);
        chk("rst_drop", {31'd0, rv[1]}, 32'd0);
        chk("rst_idle_gnt", {31'd0, gnt[1]}, 32'd1);
        nxt();
        req[1] = 1'b0;
        nxt();
        @(negedge clk);
        chk("post_rst_valid", {31'd0, rv[1]}, 32'd1);
        chk("post_rst_dat", rdat[1], 32'hDEADBEEF);
        nxt();
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int n = 0; n < 2; n++) begin
                if (!req[n] || seen_g[n]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        int r = $urandom_range(0, 9);
                        issue(n, 1'($urandom_range(0, 1)), r < 3 ? 2'b00 : r < 6 ? 2'b01 : r < 9 ? 2'b11 : 2'b10,
                              1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), $urandom);
                    end else begin
                        req[n] = 1'b0;
                    end
                end
                rdy[n] = ($urandom_range(0, 3) != 0);
            end
            nxt();
        end
        rst = 1'b0;
        req = 2'b00;
        rdy = 2'b11;
        repeat (4) nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
